ssd1963_fill_engine: RTL and testbench
======================================

# ssd1963_fill_engine

Hardware rectangle-fill engine for the SSD1963 display path. The CPU programs a window (x0..x1, y0..y1) and an RGB565 colour over an Avalon-MM control slave. On start, the engine autonomously issues the SSD1963 command/parameter/pixel byte sequence as timed Avalon-MM writes to the downstream 8-bit SSD1963 bus slave, so the bus interface is fed directly without CPU involvement.

## Interface
Parameters:
- `WR_CYCLES`, default 2: cycles each downstream write is held asserted (sets the `wr_n` low width); legal range 1..15.
- `IDLE_CYCLES`, default 1: cycles of deassertion between downstream writes; legal range 1..15.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `avs_address`  in  3  control register word index.
- `avs_write`  in  1  control write strobe.
- `avs_read`  in  1  control read strobe.
- `avs_writedata`  in  32  control write data.
- `avs_readdata`  out  32  control read data; read latency is 1.
- `avm_address`  out  4  downstream word address: 0 = command (`dc_n`=0), 1 = data (`dc_n`=1).
- `avm_writedata`  out  32  byte in [7:0]; [31:8] = 0.
- `avm_write`  out  1  downstream write.
- `avm_chipselect`  out  1  equals `avm_write`.
- `avm_byteenable`  out  4  constant 4'b0001 while writing; 0 otherwise.
- `irq`  out  1  level; set on completion, cleared by a STATUS write.

## Operation
- Register map (word index): 0 CTRL (W: bit0 start, bit1 abort); 1 STATUS (R: bit0 busy, bit1 err, bit2 done; W: any write clears done and err); 2 X0[15:0]; 3 X1; 4 Y0; 5 Y1; 6 COLOR[15:0] RGB565. Unmapped reads return 0.
- Window and colour registers are writable only while idle. Writes to them while busy are ignored.
- On start with X1<X0 or Y1<Y0: set err, set done, no bus activity, stay IDLE.
- Start while busy is ignored.
- Byte sequence (cmd = address 0, data = address 1):
  - cmd 0x2A; data X0[15:8], X0[7:0], X1[15:8], X1[7:0].
  - cmd 0x2B; data Y0 hi, Y0 lo, Y1 hi, Y1 lo.
  - cmd 0x2C.
  - For each of N=(X1-X0+1)*(Y1-Y0+1) pixels: data R8, G8, B8.
- Colour expansion: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}. Expansion happens once at start.
- Pixel count uses nested column/row counters (16-bit each, no multiplier). Order: column increments first, wrapping X1→X0, then row increments. The final pixel is (X1,Y1).
- FSM states:
  - IDLE → CMD_SETUP on a valid start.
  - CMD_SETUP walks a 0..10 step index.
  - CMD_SETUP → PIXEL; PIXEL loops through byte phases 0..2.
  - PIXEL → DONE after the B byte of the last pixel; DONE → IDLE in 1 cycle, setting done and irq.
- Each write occupies a strobe phase (WR_CYCLES cycles, with `avm_write`=1 and stable address/data), then a gap phase (IDLE_CYCLES cycles, with `avm_write`=0). The gap is driven by a shared down-counter.
- Abort while busy: the current strobe completes its WR_CYCLES. The engine then goes to IDLE with done=0, err=0 and irq=0. Abort while idle has no effect.

## Timing
- Reset values: `avs_readdata`=0, `avm_*`=0, `irq`=0, all registers 0, state IDLE.
- Reset mid-operation: all `avm_*` outputs are 0 on the cycle after reset is sampled.
- Start written at edge T: busy=1 and the first `avm_write`=1 from cycle T+1.
- Period P = WR_CYCLES+IDLE_CYCLES. Busy lasts exactly P*(11+3N) cycles, plus 1 DONE cycle. irq rises on the cycle busy falls.
- STATUS read reflects the state at the read edge; readdata is valid the following cycle.

## Structure
- Shared package `ssd1963_pkg` holds:
  - SSD1963 opcodes: CMD_SET_COLUMN=8'h2A, CMD_SET_PAGE=8'h2B, CMD_WRITE_MEM=8'h2C.
  - Register index constants.
  - Downstream address constants (ADDR_CMD=0, ADDR_DATA=1).
  - The FSM state enum.
- One sub-module, `ssd1963_wr_timer`: accepts a byte and a cmd/data flag with a req/ack handshake, and generates the strobe/gap timing. Ack is returned at the end of the gap.

## Test plan
- Window 0,0,0,0 with COLOR 0xF800, defaults → 14 writes: cmd 2A; data 00 00 00 00; cmd 2B; data 00 00 00 00; cmd 2C; data FF 00 00. Busy for 42 cycles; irq=1 afterwards.
- COLOR 0x07E0 then 0x001F, 1x1 window → pixel bytes 00 FF 00, then 00 00 FF.
- Window X 10..12, Y 5..6 → 6 pixels (18 data bytes after 2C). Parameter bytes 00 0A 00 0C / 00 05 00 06. Every `avm_write` pulse is exactly 2 cycles wide with a 1-cycle gap.
- X1=3, X0=4, then start → err=1, done=1, zero `avm_write` pulses. A STATUS write clears both flags.
- Abort at the 5th pixel → the in-flight strobe completes, there are no further writes, busy=0, irq=0. A second start, and a write to X0 during busy, are both ignored.
- reset_n=0 asserted mid-PIXEL → the next cycle shows `avm_write`=0, busy=0 and all registers 0.

Source files
------------

// File: rtl/ssd1963_pkg.sv
// rtl/ssd1963_pkg.sv - shared opcodes, register map and state type for the SSD1963 fill engine
package ssd1963_pkg;

  localparam logic [7:0] CMD_SET_COLUMN = 8'h2A;
  localparam logic [7:0] CMD_SET_PAGE   = 8'h2B;
  localparam logic [7:0] CMD_WRITE_MEM  = 8'h2C;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_X0     = 3'd2;
  localparam logic [2:0] REG_X1     = 3'd3;
  localparam logic [2:0] REG_Y0     = 3'd4;
  localparam logic [2:0] REG_Y1     = 3'd5;
  localparam logic [2:0] REG_COLOR  = 3'd6;

  localparam logic [3:0] ADDR_CMD  = 4'd0;
  localparam logic [3:0] ADDR_DATA = 4'd1;

  localparam logic [3:0] LAST_SETUP_STEP = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD_SETUP,
    ST_PIXEL,
    ST_DONE
  } fill_state_t;

  // RGB565 to packed {R8, G8, B8} by replicating the top bits into the low bits
  function automatic logic [23:0] expand_rgb565(input logic [15:0] c);
    return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
  endfunction

endpackage

// File: rtl/ssd1963_wr_timer.sv
// rtl/ssd1963_wr_timer.sv - strobe/gap timing for single downstream byte writes
module ssd1963_wr_timer
  import ssd1963_pkg::*;
#(
  parameter int WR_CYCLES   = 2,
  parameter int IDLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic [7:0]  byte_i,
  input  logic        dc_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic        strobe_o,
  output logic [3:0]  avm_address_o,
  output logic [31:0] avm_writedata_o,
  output logic        avm_write_o,
  output logic        avm_chipselect_o,
  output logic [3:0]  avm_byteenable_o
);

  localparam logic [3:0] WR_LOAD  = 4'(WR_CYCLES);
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_CYCLES);

  logic       strobe_q, strobe_d;
  logic       gap_q, gap_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d;

  // Ack on the last gap cycle lets the next request load with no dead cycle
  assign ack_o    = gap_q && (cnt_q == 4'd1);
  assign ready_o  = (!strobe_q && !gap_q) || ack_o;
  assign strobe_o = strobe_q;

  always_comb begin
    strobe_d = strobe_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    dc_d     = dc_q;
    if (strobe_q) begin
      if (cnt_q == 4'd1) begin
        strobe_d = 1'b0;
        gap_d    = 1'b1;
        cnt_d    = GAP_LOAD;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (flush_i) begin
      gap_d = 1'b0;
      cnt_d = 4'd0;
    end else if (ready_o && req_i) begin
      strobe_d = 1'b1;
      gap_d    = 1'b0;
      cnt_d    = WR_LOAD;
      byte_d   = byte_i;
      dc_d     = dc_i;
    end else if (gap_q) begin
      if (cnt_q == 4'd1) begin
        gap_d = 1'b0;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      gap_q    <= 1'b0;
      cnt_q    <= 4'd0;
      byte_q   <= 8'd0;
      dc_q     <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      dc_q     <= dc_d;
    end
  end

  assign avm_write_o      = strobe_q;
  assign avm_chipselect_o = strobe_q;
  assign avm_byteenable_o = strobe_q ? 4'b0001 : 4'b0000;
  assign avm_address_o    = strobe_q ? (dc_q ? ADDR_DATA : ADDR_CMD) : 4'd0;
  assign avm_writedata_o  = strobe_q ? {24'd0, byte_q} : 32'd0;

endmodule

// File: rtl/ssd1963_fill_engine.sv
// rtl/ssd1963_fill_engine.sv - rectangle fill engine driving the SSD1963 8-bit bus slave
module ssd1963_fill_engine
  import ssd1963_pkg::*;
#(
  parameter int WR_CYCLES   = 2,
  parameter int IDLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [3:0]  avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_chipselect,
  output logic [3:0]  avm_byteenable,
  output logic        irq
);

  fill_state_t state_q, state_d;
  logic [15:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d, color_q, color_d;
  logic [23:0] rgb_q, rgb_d;
  logic [3:0]  step_q, step_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic        last_q, last_d, abort_q, abort_d;
  logic        done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic        busy, idle, start_wr, abort_wr, status_wr;
  logic        req, req_dc, flush, wt_ready, wt_ack, wt_strobe;
  logic [7:0]  req_byte, setup_byte, pixel_byte;
  logic        setup_dc;
  logic        unused_wdata;

  assign busy         = (state_q == ST_CMD_SETUP) || (state_q == ST_PIXEL);
  assign idle         = (state_q == ST_IDLE);
  assign start_wr     = avs_write && (avs_address == REG_CTRL) && avs_writedata[0];
  assign abort_wr     = avs_write && (avs_address == REG_CTRL) && avs_writedata[1];
  assign status_wr    = avs_write && (avs_address == REG_STATUS);
  assign unused_wdata = &{1'b0, avs_writedata[31:16]};

  always_comb begin
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    if (avs_write && idle) begin
      case (avs_address)
        REG_X0:    x0_d    = avs_writedata[15:0];
        REG_X1:    x1_d    = avs_writedata[15:0];
        REG_Y0:    y0_d    = avs_writedata[15:0];
        REG_Y1:    y1_d    = avs_writedata[15:0];
        REG_COLOR: color_d = avs_writedata[15:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    if (avs_read) begin
      case (avs_address)
        REG_STATUS: rdata_d = {29'd0, done_q, err_q, busy};
        REG_X0:     rdata_d = {16'd0, x0_q};
        REG_X1:     rdata_d = {16'd0, x1_q};
        REG_Y0:     rdata_d = {16'd0, y0_q};
        REG_Y1:     rdata_d = {16'd0, y1_q};
        REG_COLOR:  rdata_d = {16'd0, color_q};
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    case (step_q)
      4'd0:    setup_byte = CMD_SET_COLUMN;
      4'd1:    setup_byte = x0_q[15:8];
      4'd2:    setup_byte = x0_q[7:0];
      4'd3:    setup_byte = x1_q[15:8];
      4'd4:    setup_byte = x1_q[7:0];
      4'd5:    setup_byte = CMD_SET_PAGE;
      4'd6:    setup_byte = y0_q[15:8];
      4'd7:    setup_byte = y0_q[7:0];
      4'd8:    setup_byte = y1_q[15:8];
      4'd9:    setup_byte = y1_q[7:0];
      default: setup_byte = CMD_WRITE_MEM;
    endcase
  end

  assign setup_dc   = !((step_q == 4'd0) || (step_q == 4'd5) || (step_q == LAST_SETUP_STEP));
  assign pixel_byte = (phase_q == 2'd0) ? rgb_q[23:16] :
                      (phase_q == 2'd1) ? rgb_q[15:8]  : rgb_q[7:0];

  always_comb begin
    state_d  = state_q;
    rgb_d    = rgb_q;
    step_d   = step_q;
    phase_d  = phase_q;
    col_d    = col_q;
    row_d    = row_q;
    last_d   = last_q;
    abort_d  = abort_q;
    done_d   = status_wr ? 1'b0 : done_q;
    err_d    = status_wr ? 1'b0 : err_q;
    irq_d    = status_wr ? 1'b0 : irq_q;
    req      = 1'b0;
    req_byte = 8'd0;
    req_dc   = 1'b0;
    flush    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          if ((x1_q < x0_q) || (y1_q < y0_q)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
            irq_d  = 1'b1;
          end else begin
            // The first command byte launches here so the strobe starts the cycle after start
            state_d  = ST_CMD_SETUP;
            req      = 1'b1;
            req_byte = CMD_SET_COLUMN;
            req_dc   = 1'b0;
            step_d   = 4'd1;
            phase_d  = 2'd0;
            col_d    = x0_q;
            row_d    = y0_q;
            last_d   = 1'b0;
            abort_d  = 1'b0;
            rgb_d    = expand_rgb565(color_q);
          end
        end
      end
      ST_CMD_SETUP, ST_PIXEL: begin
        if (abort_q) begin
          if (!wt_strobe) begin
            flush   = 1'b1;
            state_d = ST_IDLE;
            abort_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            irq_d   = 1'b0;
          end
        end else begin
          abort_d = abort_wr;
          if (state_q == ST_CMD_SETUP) begin
            req      = !abort_wr;
            req_byte = setup_byte;
            req_dc   = setup_dc;
            if (req && wt_ready) begin
              if (step_q == LAST_SETUP_STEP) begin
                state_d = ST_PIXEL;
                phase_d = 2'd0;
              end else begin
                step_d = step_q + 4'd1;
              end
            end
          end else if (last_q) begin
            if (wt_ack) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end
          end else begin
            req      = !abort_wr;
            req_byte = pixel_byte;
            req_dc   = 1'b1;
            if (req && wt_ready) begin
              if (phase_q == 2'd2) begin
                phase_d = 2'd0;
                if (col_q == x1_q) begin
                  col_d = x0_q;
                  if (row_q == y1_q) last_d = 1'b1;
                  else               row_d  = row_q + 16'd1;
                end else begin
                  col_d = col_q + 16'd1;
                end
              end else begin
                phase_d = phase_q + 2'd1;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x0_q    <= 16'd0;
      x1_q    <= 16'd0;
      y0_q    <= 16'd0;
      y1_q    <= 16'd0;
      color_q <= 16'd0;
      rgb_q   <= 24'd0;
      step_q  <= 4'd0;
      phase_q <= 2'd0;
      col_q   <= 16'd0;
      row_q   <= 16'd0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      rgb_q   <= rgb_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

  ssd1963_wr_timer #(
    .WR_CYCLES   (WR_CYCLES),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_wr_timer (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_i            (req),
    .byte_i           (req_byte),
    .dc_i             (req_dc),
    .flush_i          (flush),
    .ready_o          (wt_ready),
    .ack_o            (wt_ack),
    .strobe_o         (wt_strobe),
    .avm_address_o    (avm_address),
    .avm_writedata_o  (avm_writedata),
    .avm_write_o      (avm_write),
    .avm_chipselect_o (avm_chipselect),
    .avm_byteenable_o (avm_byteenable)
  );

endmodule

// File: tb/tb_ssd1963_fill_engine.sv
// tb/tb_ssd1963_fill_engine.sv - directed and randomized bench for ssd1963_fill_engine
module tb_ssd1963_fill_engine;

  localparam int WR  = 2;
  localparam int GAP = 1;
  localparam int P   = WR + GAP;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic [3:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_write, avm_chipselect;
  logic [3:0]  avm_byteenable;
  logic        irq;

  always #5 clk = ~clk;

  ssd1963_fill_engine #(.WR_CYCLES(WR), .IDLE_CYCLES(GAP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_read       (avs_read),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .avm_write      (avm_write),
    .avm_chipselect (avm_chipselect),
    .avm_byteenable (avm_byteenable),
    .irq            (irq)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observed downstream writes as {is_data, byte}, plus running protocol-violation counts
  logic [8:0] mon_q[$];
  logic [8:0] cur = 9'd0;
  int  widths_bad = 0, gaps_bad = 0, sig_bad = 0;
  int  width_cnt = 0, gap_cnt = 0;
  bit  in_pulse = 1'b0, seen_fall = 1'b0;

  always @(negedge clk) begin
    if (avm_chipselect !== avm_write || avm_writedata[31:8] !== 24'd0 ||
        avm_byteenable !== (avm_write ? 4'b0001 : 4'b0000))
      sig_bad++;
    if (avm_write === 1'b1) begin
      if (!in_pulse) begin
        cur = {avm_address[0], avm_writedata[7:0]};
        mon_q.push_back(cur);
        if (avm_address[3:1] !== 3'd0) sig_bad++;
        if (seen_fall && gap_cnt < 6 && gap_cnt != GAP) gaps_bad++;
        in_pulse  = 1'b1;
        width_cnt = 0;
      end else if ({avm_address[0], avm_writedata[7:0]} !== cur) begin
        sig_bad++;
      end
      width_cnt++;
    end else begin
      if (in_pulse) begin
        if (width_cnt != WR) widths_bad++;
        in_pulse  = 1'b0;
        seen_fall = 1'b1;
        gap_cnt   = 0;
      end
      gap_cnt++;
    end
  end

  logic [8:0]  exp_q[$];
  int          mon_base, widths_base, gaps_base, sig_base;
  int          busy_cycles;
  logic        first_wr;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic mark_mon();
    mon_base = mon_q.size(); widths_base = widths_bad; gaps_base = gaps_bad; sig_base = sig_bad;
  endtask

  // Reference byte stream derived directly from the window and colour
  task automatic build_model(input logic [15:0] x0, x1, y0, y1, c);
    logic [7:0] r, g, b;
    int n;
    r = {c[15:11], c[15:13]};
    g = {c[10:5], c[10:9]};
    b = {c[4:0], c[4:2]};
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, x0[15:8]}); exp_q.push_back({1'b1, x0[7:0]});
    exp_q.push_back({1'b1, x1[15:8]}); exp_q.push_back({1'b1, x1[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, y0[15:8]}); exp_q.push_back({1'b1, y0[7:0]});
    exp_q.push_back({1'b1, y1[15:8]}); exp_q.push_back({1'b1, y1[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, r}); exp_q.push_back({1'b1, g}); exp_q.push_back({1'b1, b});
    end
  endtask

  task automatic check_seq(input string tag, input int upto);
    int nbad = 0;
    for (int i = 0; i < upto; i++)
      if (mon_base + i >= mon_q.size() || mon_q[mon_base + i] !== exp_q[i]) nbad++;
    check(tag, nbad, 0);
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (mon_q.size() - mon_base < n && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (mon_q.size() - mon_base < n) check("pulse_timeout", mon_q.size() - mon_base, n);
  endtask

  task automatic run_fill(input logic [15:0] x0, x1, y0, y1, c);
    reg_wr(3'd2, {16'd0, x0}); reg_wr(3'd3, {16'd0, x1});
    reg_wr(3'd4, {16'd0, y0}); reg_wr(3'd5, {16'd0, y1});
    reg_wr(3'd6, {16'd0, c});
    build_model(x0, x1, y0, y1, c);
    mark_mon();
    reg_wr(3'd0, 32'd1);
    first_wr = avm_write;
    busy_cycles = 0;
    avs_address = 3'd1; avs_read = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #1;
      if (avs_readdata[0]) busy_cycles++;
      else break;
    end
    avs_read = 1'b0;
  endtask

  task automatic check_run(input string tag, input int npix);
    check({tag, "_busy"}, busy_cycles, P * (11 + 3 * npix));
    check({tag, "_nwrites"}, mon_q.size() - mon_base, 11 + 3 * npix);
    check_seq({tag, "_seq"}, exp_q.size());
    check({tag, "_widths"}, widths_bad - widths_base, 0);
    check({tag, "_gaps"}, gaps_bad - gaps_base, 0);
    check({tag, "_irq"}, irq, 1'b1);
    reg_rd(3'd1, rd);
    check({tag, "_status_done"}, rd, 32'd4);
    reg_wr(3'd1, 32'd0);
    check({tag, "_irq_clr"}, irq, 1'b0);
  endtask

  initial begin
    logic [15:0] rx0, ry0, rc;
    int w, h;
    reset_n = 1'b0; avs_address = 3'd0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = 32'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_avm_write", avm_write, 1'b0);
    check("rst_avm_addr", avm_address, 4'd0);
    check("rst_avm_data", avm_writedata, 32'd0);
    check("rst_avm_be", avm_byteenable, 4'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    reg_rd(3'd1, rd); check("rst_status", rd, 32'd0);
    reg_rd(3'd2, rd); check("rst_x0", rd, 32'd0);

    run_fill(16'd0, 16'd0, 16'd0, 16'd0, 16'hF800);
    check("red_first_write", first_wr, 1'b1);
    check_run("red", 1);
    check("red_sig", sig_bad - sig_base, 0);

    run_fill(16'd0, 16'd0, 16'd0, 16'd0, 16'h07E0);
    check_run("green", 1);
    run_fill(16'd0, 16'd0, 16'd0, 16'd0, 16'h001F);
    check_run("blue", 1);

    run_fill(16'd10, 16'd12, 16'd5, 16'd6, 16'($urandom));
    check_run("win3x2", 6);
    reg_rd(3'd3, rd); check("readback_x1", rd, 32'd12);
    reg_rd(3'd7, rd); check("unmapped_rd", rd, 32'd0);

    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 4); h = $urandom_range(1, 3);
      rx0 = 16'($urandom_range(0, 65000)); ry0 = 16'($urandom_range(0, 65000));
      rc = 16'($urandom);
      run_fill(rx0, rx0 + 16'(w - 1), ry0, ry0 + 16'(h - 1), rc);
      check_run("rand", w * h);
    end

    reg_wr(3'd2, 32'd4); reg_wr(3'd3, 32'd3); reg_wr(3'd4, 32'd0); reg_wr(3'd5, 32'd0);
    mark_mon();
    reg_wr(3'd0, 32'd1);
    repeat (5) @(posedge clk); #1;
    reg_rd(3'd1, rd); check("bad_win_status", rd, 32'd6);
    check("bad_win_writes", mon_q.size() - mon_base, 0);
    reg_wr(3'd1, 32'd0);
    reg_rd(3'd1, rd); check("bad_win_clr", rd, 32'd0);

    reg_wr(3'd2, 32'd100); reg_wr(3'd3, 32'd103); reg_wr(3'd4, 32'd0); reg_wr(3'd5, 32'd1);
    reg_wr(3'd6, 32'h1234);
    build_model(16'd100, 16'd103, 16'd0, 16'd1, 16'h1234);
    mark_mon();
    reg_wr(3'd0, 32'd1);
    wait_pulses(20);
    reg_wr(3'd2, 32'h5555);
    reg_wr(3'd0, 32'd1);
    wait_pulses(24);
    reg_wr(3'd0, 32'd2);
    repeat (10) @(posedge clk); #1;
    check("abort_nwrites", mon_q.size() - mon_base, 24);
    check_seq("abort_seq", 24);
    check("abort_widths", widths_bad - widths_base, 0);
    check("abort_gaps", gaps_bad - gaps_base, 0);
    check("abort_irq", irq, 1'b0);
    reg_rd(3'd1, rd); check("abort_status", rd, 32'd0);
    reg_rd(3'd2, rd); check("abort_x0_kept", rd, 32'd100);

    reg_wr(3'd2, 32'd7); reg_wr(3'd3, 32'd9); reg_wr(3'd4, 32'd1); reg_wr(3'd5, 32'd2);
    reg_wr(3'd6, 32'hABCD);
    mark_mon();
    reg_wr(3'd0, 32'd1);
    wait_pulses(15);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_avm_write", avm_write, 1'b0);
    check("midrst_avm_cs", avm_chipselect, 1'b0);
    check("midrst_avm_addr", avm_address, 4'd0);
    check("midrst_avm_data", avm_writedata, 32'd0);
    check("midrst_avm_be", avm_byteenable, 4'd0);
    check("midrst_irq", irq, 1'b0);
    reset_n = 1'b1;
    reg_rd(3'd1, rd); check("midrst_status", rd, 32'd0);
    reg_rd(3'd2, rd); check("midrst_x0", rd, 32'd0);
    reg_rd(3'd3, rd); check("midrst_x1", rd, 32'd0);
    reg_rd(3'd6, rd); check("midrst_color", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
